// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the combinational ALU: registers operands onto the ALU,
// captures result and flags, hands the result to the register file. Option: ALU_SEQ_WB_OVERLAP_EN.
module alu_sequencer #(
  parameter int DST_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_op,
  input  logic [15:0]      cmd_x,
  input  logic [15:0]      cmd_y,
  input  logic [DST_W-1:0] cmd_dst,
  input  logic             flag_load,
  input  logic [3:0]       flag_in,
  output logic [7:0]       alu_op,
  output logic [15:0]      alu_x,
  output logic [15:0]      alu_y,
  output logic [3:0]       alu_f,
  input  logic [15:0]      alu_o,
  input  logic [3:0]       alu_fresult,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [15:0]      wb_data,
  output logic [DST_W-1:0] wb_dst,
  output logic [3:0]       flags,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for a command; flag_load honoured here
  // S_EXEC | ALU settling on registered operands; result/flags captured at exit
  // S_WB   | result offered to the register file
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [7:0] OP_CP  = 8'd7;
  localparam logic [7:0] OP_SCF = 8'd20;
  localparam logic [7:0] OP_CCF = 8'd21;
  localparam logic [7:0] OP_BIT = 8'd22;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [15:0]      x_q, x_d, y_q, y_d, wb_data_q, wb_data_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic [3:0]       flags_q, flags_d;
  logic             cmd_fire, flags_only;

  assign flags_only = (op_q == OP_CP) || (op_q == OP_SCF) || (op_q == OP_CCF) ||
                      ((op_q >= OP_BIT) && (op_q <= OP_BIT + 8'd7));
  assign cmd_fire   = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_EXEC;
      S_EXEC: state_d = flags_only ? S_IDLE : S_WB;
      S_WB: begin
        if (wb_ready) begin
`ifdef ALU_SEQ_WB_OVERLAP_EN
          state_d = cmd_valid ? S_EXEC : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wb_valid  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WB: begin
        wb_valid = 1'b1;
`ifdef ALU_SEQ_WB_OVERLAP_EN
        cmd_ready = wb_ready;
`endif
      end
      default: ;
    endcase
  end

  // Datapath: the ALU result and flags pass through untouched.
  always_comb begin
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    dst_d     = dst_q;
    flags_d   = flags_q;
    wb_data_d = wb_data_q;
    if (cmd_fire) begin
      op_d  = cmd_op;
      x_d   = cmd_x;
      y_d   = cmd_y;
      dst_d = cmd_dst;
    end
    if (state_q == S_EXEC) begin
      flags_d   = alu_fresult;
      wb_data_d = alu_o;
    end else if ((state_q == S_IDLE) && flag_load && !cmd_valid) begin
      flags_d = flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      dst_q     <= '0;
      flags_q   <= '0;
      wb_data_q <= '0;
    end else begin
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dst_q     <= dst_d;
      flags_q   <= flags_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign alu_op  = op_q;
  assign alu_x   = x_q;
  assign alu_y   = y_q;
  assign alu_f   = flags_q;
  assign flags   = flags_q;
  assign wb_data = wb_data_q;
  assign wb_dst  = dst_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural 8-bit ALU stub plus a writeback scoreboard.
module tb_alu_sequencer;

  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_ADC = 8'd1;
  localparam logic [7:0] OP_SUB = 8'd2;
  localparam logic [7:0] OP_AND = 8'd4;
  localparam logic [7:0] OP_CP  = 8'd7;
  localparam logic [7:0] OP_SCF = 8'd20;
  localparam logic [7:0] OP_CCF = 8'd21;
  localparam logic [7:0] OP_BIT = 8'd22;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_x, cmd_y;
  logic [3:0]  cmd_dst;
  logic        flag_load;
  logic [3:0]  flag_in;
  logic [7:0]  alu_op;
  logic [15:0] alu_x, alu_y, alu_o;
  logic [3:0]  alu_f, alu_fresult;
  logic        wb_valid, wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_dst, flags;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0]  exp_flags;
  logic [15:0] q_data[$];
  logic [3:0]  q_dst[$];

  alu_sequencer #(.DST_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_dst(cmd_dst),
    .flag_load(flag_load), .flag_in(flag_in),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_f(alu_f),
    .alu_o(alu_o), .alu_fresult(alu_fresult),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dst(wb_dst),
    .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic is_flags_only(input logic [7:0] op);
    return (op == OP_CP) || (op == OP_SCF) || (op == OP_CCF) ||
           ((op >= OP_BIT) && (op <= OP_BIT + 8'd7));
  endfunction

  // Returns {flags, result}; 8-bit arithmetic zero-extended to 16 bits.
  function automatic logic [19:0] alu_ref(input logic [7:0] op, input logic [15:0] x,
                                          input logic [15:0] y, input logic [3:0] f);
    logic [8:0]  r;
    logic [4:0]  h;
    logic        c;
    logic [7:0]  a;
    logic [2:0]  idx;
    logic [15:0] o;
    logic [3:0]  nf;
    o = x;
    nf = f;
    c = (op == OP_ADC) ? f[0] : 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        r  = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'h00, c};
        h  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'h0, c};
        o  = {8'h00, r[7:0]};
        nf = {r[7:0] == 8'h00, 1'b0, h[4], r[8]};
      end
      OP_SUB, OP_CP: begin
        r  = {1'b0, x[7:0]} - {1'b0, y[7:0]};
        o  = (op == OP_SUB) ? {8'h00, r[7:0]} : x;
        nf = {r[7:0] == 8'h00, 1'b1, x[3:0] < y[3:0], x[7:0] < y[7:0]};
      end
      OP_AND: begin
        a  = x[7:0] & y[7:0];
        o  = {8'h00, a};
        nf = {a == 8'h00, 1'b0, 1'b1, 1'b0};
      end
      OP_SCF: nf = {f[3], 3'b001};
      OP_CCF: nf = {f[3], 2'b00, ~f[0]};
      default: begin
        if ((op >= OP_BIT) && (op <= OP_BIT + 8'd7)) begin
          idx = op[2:0] - OP_BIT[2:0];
          nf  = {~x[idx], 1'b0, 1'b1, f[0]};
        end
      end
    endcase
    return {nf, o};
  endfunction

  always_comb {alu_fresult, alu_o} = alu_ref(alu_op, alu_x, alu_y, alu_f);

  // Scoreboard: inputs only change just after posedge, so a handshake seen here lands next edge.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      n_checks++;
      if (q_data.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_wb: got data=%h dst=%h, required no writeback", wb_data, wb_dst);
      end else begin
        if (wb_data !== q_data[0] || wb_dst !== q_dst[0]) begin
          n_fail++;
          $display("FAIL sb_wb: got data=%h dst=%h, required data=%h dst=%h",
                   wb_data, wb_dst, q_data[0], q_dst[0]);
        end
        void'(q_data.pop_front());
        void'(q_dst.pop_front());
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] dst, input bit hold, output int acc_cyc);
    logic [19:0] r;
    int t;
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_dst = dst; cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
    end
    acc_cyc = cyc;
    r = alu_ref(op, x, y, exp_flags);
    exp_flags = r[19:16];
    if (!is_flags_only(op)) begin
      q_data.push_back(r[15:0]);
      q_dst.push_back(dst);
    end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] v);
    flag_load = 1'b1; flag_in = v;
    @(posedge clk); #1;
    flag_load = 1'b0;
    exp_flags = v;
  endtask

  task automatic drain();
    int t;
    wb_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (busy || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL drain: busy=%b pending=%0d, required busy=0 pending=0", busy, q_data.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || flags !== 4'h0 ||
        alu_op !== 8'h00 || alu_x !== 16'h0 || alu_y !== 16'h0 || wb_data !== 16'h0 || wb_dst !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b busy=%b wbv=%b flags=%b op=%h x=%h y=%h wbd=%h dst=%h, required 1 0 0 0000 all zero",
               cmd_ready, busy, wb_valid, flags, alu_op, alu_x, alu_y, wb_data, wb_dst);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_flags = 4'h0;
  endtask

  task automatic test_add();
    int a;
    issue(OP_ADD, 16'h003A, 16'h00C6, 4'h9, 1'b0, a);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || wb_valid !== 1'b0 || alu_op !== OP_ADD || alu_x !== 16'h003A || alu_y !== 16'h00C6) begin
      n_fail++;
      $display("FAIL add_exec: busy=%b wbv=%b op=%h x=%h y=%h, required 1 0 00 003a 00c6",
               busy, wb_valid, alu_op, alu_x, alu_y);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h0000 || wb_dst !== 4'h9 || flags !== 4'b1011) begin
      n_fail++;
      $display("FAIL add_wb: wbv=%b data=%h dst=%h flags=%b, required 1 0000 9 1011",
               wb_valid, wb_data, wb_dst, flags);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done: wbv=%b busy=%b, required 0 0", wb_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cp();
    int a;
    issue(OP_CP, 16'h0010, 16'h0010, 4'h3, 1'b0, a);
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cp_exec: rdy=%b busy=%b, required 0 1", cmd_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || wb_valid !== 1'b0 || flags !== 4'b1100) begin
      n_fail++;
      $display("FAIL cp_done: rdy=%b wbv=%b flags=%b, required 1 0 1100", cmd_ready, wb_valid, flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    int a;
    load_flags(4'b0000);
    issue(OP_SCF, 16'h0000, 16'h0000, 4'h0, 1'b0, a);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (flags !== 4'b0001) begin
      n_fail++;
      $display("FAIL scf_flags: got %b, required 0001", flags);
    end
    @(posedge clk); #1;
    issue(OP_ADC, 16'h0001, 16'h0001, 4'h4, 1'b0, a);
    @(negedge clk);
    n_checks++;
    if (alu_f !== 4'b0001) begin
      n_fail++;
      $display("FAIL adc_alu_f: got %b, required 0001", alu_f);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h0003 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL adc_wb: wbv=%b data=%h flags=%b, required 1 0003 0000", wb_valid, wb_data, flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int a;
    wb_ready = 1'b0;
    issue(OP_ADD, 16'h0012, 16'h0034, 4'h5, 1'b0, a);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_x = 16'h00FF; cmd_y = 16'h0001; cmd_dst = 4'hE;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_data !== 16'h0046 || wb_dst !== 4'h5 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: wbv=%b data=%h dst=%h rdy=%b, required 1 0046 5 0",
                 i, wb_valid, wb_data, wb_dst, cmd_ready);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: wbv=%b busy=%b, required 0 0", wb_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flag_load();
    int a;
    load_flags(4'b1010);
    @(negedge clk);
    n_checks++;
    if (flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL flag_load: got %b, required 1010", flags);
    end
    @(posedge clk); #1;
    flag_load = 1'b1; flag_in = 4'b0101;
    issue(OP_ADD, 16'h0001, 16'h0001, 4'h2, 1'b0, a);
    flag_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (flags !== 4'b1010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flag_collision: flags=%b busy=%b, required 1010 1", flags, busy);
    end
    @(negedge clk);
    n_checks++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL flag_collision_exec: flags=%b, required 0000", flags);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int gap;
`ifdef ALU_SEQ_WB_OVERLAP_EN
    gap = 2;
`else
    gap = 3;
`endif
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(OP_ADD, 16'(i * 17), 16'(i + 3), 4'(i + 8), 1'b1, acc[i]);
    cmd_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != gap) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: got %0d cycles, required %0d", i, acc[i] - acc[i-1], gap);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int a;
    wb_ready = 1'b0;
    issue(OP_ADD, 16'h0080, 16'h0080, 4'hC, 1'b0, a);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: wbv=%b, required 1", wb_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || flags !== 4'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: wbv=%b flags=%b busy=%b, required 0 0000 0", wb_valid, flags, busy);
    end
    q_data.delete();
    q_dst.delete();
    exp_flags = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: rdy=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_wb[%0d]: wbv=%b, required 0", i, wb_valid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_dst = '0;
    flag_load = 1'b0; flag_in = '0;
    wb_ready = 1'b1;
    exp_flags = 4'h0;
    test_reset();
    test_add();
    test_cp();
    test_carry_chain();
    test_backpressure();
    test_flag_load();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue and writeback controller on the CPU side of the combinational ALU. It accepts ALU commands over a valid/ready handshake and registers the operands onto the ALU inputs. It then captures the ALU result and flags, maintains the architectural flag nibble, and presents the result to the register file over a second valid/ready handshake. It sits between instruction decode and the register file, and drives the ALU's op/X/Y/F inputs from its own state.

## Interface
Parameters:
- DST_W, 4, width of destination register tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  8  ALU op code, in the ALU's own encoding (ADD…SET+7).
- cmd_x  in  16  first operand.
- cmd_y  in  16  second operand.
- cmd_dst  in  DST_W  destination register tag.
- flag_load  in  1  load flags from flag_in (POP AF); honoured only in IDLE.
- flag_in  in  4  flag value to load, {Z,N,H,C}.
- alu_op  out  8  registered op to ALU.
- alu_x  out  16  registered X to ALU.
- alu_y  out  16  registered Y to ALU.
- alu_f  out  4  current flag register to ALU.
- alu_o  in  16  ALU result.
- alu_fresult  in  4  ALU result flags.
- wb_valid  out  1  writeback present.
- wb_ready  in  1  register file accepts writeback.
- wb_data  out  16  captured result.
- wb_dst  out  DST_W  captured destination tag.
- flags  out  4  architectural flag register {Z,N,H,C}.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
States are IDLE, EXEC and WB.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid, latch op/x/y/dst into alu_* and the dst register, then go to EXEC.
  - flag_load without cmd_valid: flags ← flag_in.
  - flag_load together with cmd_valid: the command is accepted and flag_in is ignored.
- **EXEC:** lasts exactly one cycle; the ALU settles combinationally.
  - At the closing edge: flags ← alu_fresult, wb_data ← alu_o.
  - Flags-only ops (CP, SCF, CCF, BIT+0..7) go to IDLE with no writeback.
  - All other ops go to WB.
- **WB:**
  - wb_valid=1; wb_data and wb_dst are held stable.
  - On wb_ready, go to IDLE.
  - wb_valid never drops without wb_ready.
- alu_f always equals flags, so ADC, SBC, RL, RR, DAA and CCF see the flags produced by the previous op.
- Arithmetic is done entirely by the ALU. The sequencer does not modify the 16-bit result or the 4-bit flags.
- Reset (async, any state):
  - State goes to IDLE and any in-flight command is dropped.
  - flags, alu_op, alu_x, alu_y, wb_data and wb_dst go to 0.
  - wb_valid=0, busy=0, cmd_ready=1 one settle after reset release.

## Timing
- Command accepted at edge N. EXEC occupies cycle N→N+1. flags are updated at edge N+1.
- Write op: wb_valid is high from edge N+1. Writeback completes at the first edge with wb_ready, earliest N+2.
- Flags-only op: cmd_ready returns at edge N+1, giving a throughput of one command per 2 cycles.
- Write op with wb_ready held high: one command per 3 cycles (without the macro below).
- cmd_ready is combinational from state only; it never depends on cmd_valid.

## Configuration
- Macro `ALU_SEQ_WB_OVERLAP_EN`.
- **Defined:**
  - In WB, cmd_ready = wb_ready.
  - A command accepted on the same edge as the writeback handshake goes directly WB→EXEC.
  - Sustained throughput is one write op per 2 cycles.
  - The new command's alu_f is the flags captured by the previous EXEC.
- **Undefined:**
  - cmd_ready=0 in WB.
  - The WB→IDLE transition is mandatory.

## Test plan
- **ADD:** cmd ADD x=0x003A y=0x00C6, F=0000.
  - Flags become 1011 at N+1.
  - wb_valid with wb_data=0x0000 and wb_dst=cmd_dst.
- **CP (flags-only):** CP x=0x0010 y=0x0010.
  - Flags become 1100.
  - wb_valid stays 0.
  - cmd_ready is high again at N+1.
- **Carry chaining:** SCF (flags 0001), then ADC x=0x0001 y=0x0001.
  - alu_f=0001 during the ADC EXEC.
  - wb_data=0x0003.
- **Backpressure:** write op with wb_ready=0 for 5 cycles.
  - wb_valid, wb_data and wb_dst are held stable.
  - cmd_ready=0 and cmd_valid is ignored.
  - Released one edge after wb_ready=1.
- **flag_load collision:** in IDLE, flag_load=1 with flag_in=1010, no cmd, gives flags=1010. Then flag_load together with a cmd: the command is taken and flags are unchanged by flag_in.
- **Reset mid-operation:** assert rst_n=0 in WB.
  - Immediately wb_valid=0, flags=0000, busy=0.
  - After release, cmd_ready=1 and no writeback appears.
  - With the macro defined: back-to-back ADD ops with wb_ready=1 are accepted every 2 cycles.
